// File: rtl/fetch_pkg_defs.sv
// Shared definitions for the fetch packetizer: FSM state encoding, default
// header byte and the checksum helper.
package fetch_pkg_defs;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HEAD = 3'd1;
  localparam logic [2:0] ST_MODB = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_PHI  = 3'd4;
  localparam logic [2:0] ST_PLO  = 3'd5;
  localparam logic [2:0] ST_SUM  = 3'd6;

  localparam logic [7:0] HEAD_BYTE_DEF = 8'hA5;

  function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/fetch_word_fifo.sv
// Synchronous 16-bit word FIFO with first-word-fall-through read data.
// A push while full is accepted when a pop happens in the same cycle.
module fetch_word_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic [15:0] wdata_i,
  output logic [15:0] rdata_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [15:0] mem_q [DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  logic        wr_en_s;
  logic        rd_en_s;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
  assign wr_en_s = push_i && (!full_o || pop_i);
  assign rd_en_s = pop_i && !empty_o;

  // Pointers carry one extra wrap bit to tell full from empty.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      end
      if (rd_en_s) begin
        rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/fetch_pkg.sv
// Packetizer: header, module byte, payload bytes (word MSB first) and, with
// FETCH_PKG_SUM_EN defined, a trailing modulo-256 payload checksum byte.
module fetch_pkg
  import fetch_pkg_defs::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] HEAD_BYTE  = HEAD_BYTE_DEF
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        fire_sync,
  input  logic [15:0] len_pkg,
  input  logic [5:0]  mod_id,
  input  logic [15:0] rx_data,
  input  logic        rx_vld,
  output logic [7:0]  pkg_data,
  output logic        pkg_vld,
  output logic        pkg_frm,
  output logic        busy,
  output logic        err_ovf
);

`ifdef FETCH_PKG_SUM_EN
  localparam logic [2:0] ST_DONE = ST_SUM;
`else
  localparam logic [2:0] ST_DONE = ST_IDLE;
`endif

  logic [2:0]  state_q, state_d;
  logic [14:0] nwords_q, nwords_d;
  logic [14:0] acc_q, acc_d;
  logic [14:0] sent_q, sent_d;
  logic [5:0]  mod_q, mod_d;
  logic [7:0]  lo_q, lo_d;
  logic [7:0]  data_q, data_d;
  logic        vld_q, vld_d;
  logic        frm_q, frm_d;
  logic        err_q, err_d;
`ifdef FETCH_PKG_SUM_EN
  logic [7:0]  sum_q, sum_d;
`endif

  logic        wr_req_s;
  logic        fifo_push_s;
  logic        fifo_pop_s;
  logic        fifo_flush_s;
  logic        fifo_full_s;
  logic        fifo_empty_s;
  logic [15:0] fifo_rdata_s;
  logic        len_unused_s;

  assign len_unused_s = len_pkg[0];

  fetch_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_sys),
    .rst_ni  (rst_n),
    .flush_i (fifo_flush_s),
    .push_i  (fifo_push_s),
    .pop_i   (fifo_pop_s),
    .wdata_i (rx_data),
    .rdata_o (fifo_rdata_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  always_comb begin
    state_d    = state_q;
    nwords_d   = nwords_q;
    mod_d      = mod_q;
    sent_d     = sent_q;
    fifo_pop_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fire_sync) begin
          state_d  = ST_HEAD;
          nwords_d = len_pkg[15:1];
          mod_d    = mod_id;
          sent_d   = 15'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HEAD: state_d = ST_MODB;
      ST_MODB: begin
        if (nwords_q == 15'd0) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!fifo_empty_s) begin
          fifo_pop_s = 1'b1;
          state_d    = ST_PHI;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_PHI: state_d = ST_PLO;
      ST_PLO: begin
        sent_d = sent_q + 15'd1;
        if (sent_d == nwords_q) begin
          state_d = ST_DONE;
        end else if (!fifo_empty_s) begin
          fifo_pop_s = 1'b1;
          state_d    = ST_PHI;
        end else begin
          state_d = ST_WAIT;
        end
      end
`ifdef FETCH_PKG_SUM_EN
      ST_SUM: state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Output byte is chosen from the next state so it is registered with it.
  always_comb begin
    wr_req_s     = rx_vld && (state_q != ST_IDLE) && (acc_q < nwords_q);
    fifo_push_s  = wr_req_s && (!fifo_full_s || fifo_pop_s);
    fifo_flush_s = (state_q != ST_IDLE) && (state_d == ST_IDLE);
    err_d        = err_q | (wr_req_s && fifo_full_s && !fifo_pop_s);
    if (state_q == ST_IDLE) begin
      acc_d = 15'd0;
    end else if (fifo_push_s) begin
      acc_d = acc_q + 15'd1;
    end else begin
      acc_d = acc_q;
    end
    if (fifo_pop_s) begin
      lo_d = fifo_rdata_s[7:0];
    end else begin
      lo_d = lo_q;
    end
    vld_d = 1'b1;
    frm_d = 1'b1;
    case (state_d)
      ST_HEAD: data_d = HEAD_BYTE;
      ST_MODB: data_d = {2'b00, mod_q};
      ST_PHI:  data_d = fifo_rdata_s[15:8];
      ST_PLO:  data_d = lo_q;
`ifdef FETCH_PKG_SUM_EN
      ST_SUM:  data_d = sum_q;
`endif
      ST_WAIT: begin
        data_d = 8'h00;
        vld_d  = 1'b0;
      end
      default: begin
        data_d = 8'h00;
        vld_d  = 1'b0;
        frm_d  = 1'b0;
      end
    endcase
`ifdef FETCH_PKG_SUM_EN
    if (state_q == ST_IDLE) begin
      sum_d = 8'h00;
    end else if ((state_d == ST_PHI) || (state_d == ST_PLO)) begin
      sum_d = sum8(sum_q, data_d);
    end else begin
      sum_d = sum_q;
    end
`endif
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      nwords_q <= 15'd0;
      acc_q    <= 15'd0;
      sent_q   <= 15'd0;
      mod_q    <= 6'd0;
      lo_q     <= 8'h00;
      data_q   <= 8'h00;
      vld_q    <= 1'b0;
      frm_q    <= 1'b0;
      err_q    <= 1'b0;
`ifdef FETCH_PKG_SUM_EN
      sum_q    <= 8'h00;
`endif
    end else begin
      state_q  <= state_d;
      nwords_q <= nwords_d;
      acc_q    <= acc_d;
      sent_q   <= sent_d;
      mod_q    <= mod_d;
      lo_q     <= lo_d;
      data_q   <= data_d;
      vld_q    <= vld_d;
      frm_q    <= frm_d;
      err_q    <= err_d;
`ifdef FETCH_PKG_SUM_EN
      sum_q    <= sum_d;
`endif
    end
  end

  assign pkg_data = data_q;
  assign pkg_vld  = vld_q;
  assign pkg_frm  = frm_q;
  assign busy     = (state_q != ST_IDLE);
  assign err_ovf  = err_q;

endmodule
